// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI3 write-path slave.
package axi_pkg;

  localparam int AXI_ID_W = 8;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t DATA = 2'd1;
  localparam state_t RESP = 2'd2;

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Next beat address for FIXED/INCR/WRAP bursts and burst-level legality.
module axi_wr_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        size,
  input  logic [3:0]        len,
  input  burst_t            burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              burst_ok
);

  logic [ADDR_W-1:0] sz;
  logic [ADDR_W-1:0] wb;
  logic              wrap_len_ok;
  logic              wrap_ok;

  always_comb begin
    sz = ADDR_W'(1) << size;
    wb = (ADDR_W'(len) + ADDR_W'(1)) << size;
    next_addr = addr;
    unique case (1'b1)
      burst == INCR:
        next_addr = (addr & ~(sz - ADDR_W'(1))) + sz;
      burst == WRAP:
        next_addr = (addr & ~(wb - ADDR_W'(1)))
                  | ((addr + sz) & (wb - ADDR_W'(1)));
      default:
        next_addr = addr;
    endcase
    wrap_len_ok = (len == 4'd1) || (len == 4'd3)
               || (len == 4'd7) || (len == 4'd15);
    // Wrap alignment survives every wrap step, so checking the live address is enough
    wrap_ok = wrap_len_ok && ((addr & (sz - ADDR_W'(1))) == '0);
    burst_ok = (size <= 4'd2) && (burst != RSVD)
            && ((burst != WRAP) || wrap_ok);
  end

endmodule

// File: rtl/axi_wr_slave_ctrl.sv
// AXI3 write slave: one burst at a time, one SRAM word write per accepted beat.
module axi_wr_slave_ctrl
  import axi_pkg::*;
#(
  parameter int ID_W      = AXI_ID_W,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 1024,
  localparam int MEM_AW   = $clog2(MEM_DEPTH)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [3:0]        awlen,
  input  logic [3:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [3:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb
);

  localparam logic [ADDR_W-3:0] DEPTH = (ADDR_W-2)'(MEM_DEPTH);

  state_t            state;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [3:0]        size_q;
  burst_t            burst_q;
  logic              err_q;
  logic [3:0]        cnt_q;

  logic [ADDR_W-1:0] next_addr;
  logic              burst_ok;
  logic              last;
  logic              beat_ok;
  logic              unused_ok;

  assign unused_ok = ^{awlock, awcache, awprot};

  axi_wr_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .burst_ok  (burst_ok)
  );

  always_comb begin
    last    = (cnt_q == len_q);
    beat_ok = burst_ok && (wid == id_q) && (wlast == last)
           && (addr_q[ADDR_W-1:2] < DEPTH);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= RESP_OKAY;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= FIXED;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            id_q    <= awid;
            addr_q  <= awaddr;
            len_q   <= awlen;
            size_q  <= awsize;
            burst_q <= burst_t'(awburst);
            err_q   <= 1'b0;
            cnt_q   <= '0;
            awready <= 1'b0;
            wready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (wvalid && wready) begin
            mem_we <= beat_ok;
            if (beat_ok) begin
              mem_addr  <= addr_q[MEM_AW+1:2];
              mem_wdata <= wdata;
              mem_wstrb <= wstrb;
            end
            err_q  <= err_q | ~beat_ok;
            cnt_q  <= cnt_q + 4'd1;
            addr_q <= next_addr;
            // Burst length comes from awlen alone; wlast only feeds the error check
            if (last) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= (err_q || !beat_ok) ? RESP_SLVERR : RESP_OKAY;
              state  <= RESP;
            end
          end
        end
        RESP: begin
          if (bvalid && bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_slave_ctrl.sv
// Scoreboard bench for axi_wr_slave_ctrl: directed cases then randomized bursts.
module tb_axi_wr_slave_ctrl;

  localparam int ID_W      = 8;
  localparam int ADDR_W    = 32;
  localparam int MEM_DEPTH = 1024;
  localparam int MEM_AW    = 10;

  logic              aclk;
  logic              aresetn;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [3:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [3:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;

  typedef struct {
    logic [MEM_AW-1:0] a;
    logic [31:0]       d;
    logic [3:0]        s;
  } wr_t;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [1:0]      r;
  } b_t;

  wr_t wq[$];
  b_t  bq[$];
  int  nvec = 0;
  int  nerr = 0;

  axi_wr_slave_ctrl #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: timed out waiting on DUT", name);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "timeout");
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a response
  always @(negedge aclk) begin : monitor
    wr_t ew;
    b_t  eb;
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL mem_we_unexpected: got write to %0h, expected none",
                 mem_addr);
      end else begin
        ew = wq.pop_front();
        check("mem_addr", 64'(mem_addr), 64'(ew.a));
        check("mem_wdata", 64'(mem_wdata), 64'(ew.d));
        check("mem_wstrb", 64'(mem_wstrb), 64'(ew.s));
      end
    end
    if (bvalid === 1'b1 && bready === 1'b1) begin
      if (bq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL b_unexpected: got bid %0h, expected none", bid);
      end else begin
        eb = bq.pop_front();
        check("bid", 64'(bid), 64'(eb.id));
        check("bresp", 64'(bresp), 64'(eb.r));
      end
    end
  end

  // Reference address stepping from the burst rules, using plain arithmetic
  function automatic logic [31:0] model_next(input logic [31:0] a,
                                             input int size, input int len,
                                             input int burst);
    logic [31:0] sz;
    logic [31:0] wb;
    sz = 32'd1 << size;
    wb = 32'(len + 1) * sz;
    case (burst)
      1:       return (a / sz) * sz + sz;
      2:       return (a / wb) * wb + ((a + sz) % wb);
      default: return a;
    endcase
  endfunction

  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr,
                           input int len, input int size, input int burst,
                           input int bad_wid, input int early_last,
                           input bit drop_last, input int abort_after,
                           input int bhold);
    logic [31:0] d[16];
    logic [3:0]  s[16];
    logic [7:0]  wi[16];
    logic        wl[16];
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] sz;
    logic [1:0]  exp_r;
    bit          berr;
    bit          err;
    bit          ok;
    int          n;
    int          t;

    sz = 32'd1 << size;
    berr = (size > 2) || (burst == 3)
        || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
        || (burst == 2 && (addr % sz) != 0);
    n = (abort_after >= 0) ? abort_after : len + 1;
    err = berr;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      d[i]  = $urandom;
      s[i]  = 4'($urandom);
      wi[i] = (i == bad_wid) ? (id ^ 8'h01) : id;
      wl[i] = (i == len) ? !drop_last : (i == early_last);
      w = a >> 2;
      ok = !berr && (wi[i] == id) && (wl[i] == (i == len))
        && (w < MEM_DEPTH);
      if (i < n && ok) wq.push_back('{w[MEM_AW-1:0], d[i], s[i]});
      if (!ok) err = 1'b1;
      a = model_next(a, size, len, burst);
    end
    exp_r = err ? 2'b10 : 2'b00;
    if (abort_after < 0) bq.push_back('{id, exp_r});

    awid    = id;
    awaddr  = addr;
    awlen   = 4'(len);
    awsize  = 4'(size);
    awburst = 2'(burst);
    awlock  = 2'($urandom);
    awcache = 4'($urandom);
    awprot  = 4'($urandom);
    awvalid = 1'b1;
    t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!awready && t < 200);
    if (!awready) timeout("aw_wait");
    @(posedge aclk);
    #1 awvalid = 1'b0;

    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge aclk);
        #1;
      end
      wid    = wi[i];
      wdata  = d[i];
      wstrb  = s[i];
      wlast  = wl[i];
      wvalid = 1'b1;
      t = 0;
      do begin
        @(negedge aclk);
        t++;
      end while (!wready && t < 200);
      if (!wready) timeout("w_wait");
      @(posedge aclk);
      #1 wvalid = 1'b0;
    end

    if (abort_after >= 0) begin
      aresetn = 1'b0;
      @(posedge aclk);
      #1 aresetn = 1'b1;
      check("abort_bvalid", 64'(bvalid), 64'd0);
      check("abort_mem_we", 64'(mem_we), 64'd0);
      @(posedge aclk);
      #1;
      check("abort_awready", 64'(awready), 64'd1);
      check("abort_bvalid2", 64'(bvalid), 64'd0);
      return;
    end

    t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!bvalid && t < 200);
    if (!bvalid) timeout("b_wait");
    for (int k = 0; k < bhold; k++) begin
      check("hold_bvalid", 64'(bvalid), 64'd1);
      check("hold_bid", 64'(bid), 64'(id));
      check("hold_bresp", 64'(bresp), 64'(exp_r));
      check("hold_awready", 64'(awready), 64'd0);
      @(negedge aclk);
    end
    @(posedge aclk);
    #1 bready = 1'b1;
    @(posedge aclk);
    #1 bready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int size;
    int burst;
    logic [31:0] addr;
    logic [31:0] msk;

    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_bid", 64'(bid), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("rel_awready0", 64'(awready), 64'd0);
    @(posedge aclk);
    #1;
    check("rel_awready1", 64'(awready), 64'd1);

    run_burst(8'h5A, 32'h100, 3, 2, 1, -1, -1, 1'b0, -1, 0);
    run_burst(8'h21, 32'h38, 3, 2, 2, -1, -1, 1'b0, -1, 1);
    run_burst(8'h10, 32'h20, 2, 1, 0, 1, -1, 1'b0, -1, 0);
    run_burst(8'h33, 32'h200, 1, 2, 1, -1, 0, 1'b0, -1, 5);
    run_burst(8'h44, 32'h40, 0, 2, 3, -1, -1, 1'b0, -1, 0);
    run_burst(8'h45, 32'h40, 0, 3, 1, -1, -1, 1'b0, -1, 0);
    run_burst(8'h46, 32'h1000, 0, 2, 1, -1, -1, 1'b0, -1, 0);
    run_burst(8'h47, 32'h10, 2, 2, 1, -1, -1, 1'b1, -1, 0);
    run_burst(8'h48, 32'h34, 4, 2, 2, -1, -1, 1'b0, -1, 0);
    run_burst(8'h49, 32'hFFC, 1, 2, 1, -1, -1, 1'b0, -1, 0);
    run_burst(8'h77, 32'h300, 7, 2, 1, -1, -1, 1'b0, 3, 0);
    run_burst(8'h78, 32'h304, 0, 2, 1, -1, -1, 1'b0, -1, 0);

    for (int r = 0; r < 40; r++) begin
      burst = $urandom_range(0, 7);
      burst = (burst > 3) ? 1 : burst;
      size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      len   = $urandom_range(0, 15);
      if (burst == 2 && $urandom_range(0, 4) != 0) begin
        len = (4 << $urandom_range(0, 2)) - 1;
        len = ($urandom_range(0, 3) == 0) ? 1 : len;
      end
      addr = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 4095);
      msk = (32'd1 << size) - 32'd1;
      if ($urandom_range(0, 4) != 0) addr = addr & ~msk;
      run_burst(8'($urandom), addr, len, size, burst,
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1,
                ($urandom_range(0, 7) == 0 && len > 0)
                  ? $urandom_range(0, len - 1) : -1,
                ($urandom_range(0, 9) == 0),
                -1, $urandom_range(0, 3));
    end

    repeat (3) @(posedge aclk);
    check("wq_drained", 64'(wq.size()), 64'd0);
    check("bq_drained", 64'(bq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
